// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave sequencing controller: state codes and beep sizing.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_COOK  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int BEEP_W          = 10;
  localparam int BEEP_CYCLES_DEF = 300;

endpackage

// File: rtl/press_detect_n.sv
// Press-edge detector for an active-low push button: one-cycle pulse on a new press.
module press_detect_n (
  input  logic clk,
  input  logic clearn,
  input  logic btn_n,
  output logic press
);

  // held remembers "button was down last cycle"; forcing it to 1 in reset
  // means a button held through reset must be released before it counts.
  logic held;

  always_ff @(posedge clk) begin
    if (!clearn) held <= 1'b1;
    else         held <= ~btn_n;
  end

  assign press = ~btn_n & ~held;

endmodule

// File: rtl/microwave_controller.sv
// Top-level microwave sequencer: entry, load, cook, pause, done/beep.
// Optional pulsed beep pattern enabled by defining MWC_BEEP_PULSE_EN.
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int BEEP_CYCLES = BEEP_CYCLES_DEF
`ifdef MWC_BEEP_PULSE_EN
  , parameter int BEEP_HALF = 50
`endif
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic       entry_zero,
  input  logic       time_zero,
  output logic       timer_enablen,
  output logic       count_loadn,
  output logic       count_en,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  localparam logic [BEEP_W-1:0] BEEP_LIM = BEEP_W'(BEEP_CYCLES);

  state_t            cur, nxt;
  logic              start_p, stop_p;
  logic              fresh_cook;
  logic [BEEP_W-1:0] beep_cnt, beep_cnt_d;
  logic              timer_enablen_d, count_loadn_d, count_en_d, mag_on_d, beep_d;

`ifdef MWC_BEEP_PULSE_EN
  localparam int            PH_W    = 11;
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(BEEP_HALF);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * BEEP_HALF - 1);
  logic [PH_W-1:0] phase, phase_d;
`endif

  press_detect_n u_start (.clk(clk), .clearn(clearn), .btn_n(startn), .press(start_p));
  press_detect_n u_stop  (.clk(clk), .clearn(clearn), .btn_n(stopn),  .press(stop_p));

  // State register; every output is registered from the next state so it
  // changes on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (!clearn) begin
      cur           <= ST_IDLE;
      fresh_cook    <= 1'b0;
      beep_cnt      <= '0;
      timer_enablen <= 1'b0;
      count_loadn   <= 1'b1;
      count_en      <= 1'b0;
      mag_on        <= 1'b0;
      beep          <= 1'b0;
`ifdef MWC_BEEP_PULSE_EN
      phase         <= '0;
`endif
    end else begin
      cur           <= nxt;
      fresh_cook    <= (cur == ST_LOAD) && (nxt == ST_COOK);
      beep_cnt      <= beep_cnt_d;
      timer_enablen <= timer_enablen_d;
      count_loadn   <= count_loadn_d;
      count_en      <= count_en_d;
      mag_on        <= mag_on_d;
      beep          <= beep_d;
`ifdef MWC_BEEP_PULSE_EN
      phase         <= phase_d;
`endif
    end
  end

  // Next state: stop beats door-open beats time_zero beats start.
  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE:  if (!stop_p && key_valid) nxt = ST_SET;
      ST_SET: begin
        if (stop_p)                                       nxt = ST_IDLE;
        else if (start_p && door_closed && !entry_zero)   nxt = ST_LOAD;
      end
      ST_LOAD:  nxt = stop_p ? ST_IDLE : ST_COOK;
      ST_COOK: begin
        if (stop_p || !door_closed)                       nxt = ST_PAUSE;
        else if (time_zero && !fresh_cook)                nxt = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop_p)                                       nxt = ST_IDLE;
        else if (start_p && door_closed && !time_zero)    nxt = ST_COOK;
      end
      ST_DONE:  if (stop_p || !door_closed)               nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state, plus the saturating beep counter.
  always_comb begin
    timer_enablen_d = (nxt != ST_IDLE);
    count_loadn_d   = (nxt != ST_LOAD);
    count_en_d      = (nxt == ST_COOK);
    mag_on_d        = (nxt == ST_COOK);
    beep_cnt_d      = '0;
    if (nxt == ST_DONE && cur == ST_DONE)
      beep_cnt_d = (beep_cnt < BEEP_LIM) ? beep_cnt + BEEP_W'(1) : beep_cnt;
    beep_d = (nxt == ST_DONE) && (beep_cnt_d < BEEP_LIM);
`ifdef MWC_BEEP_PULSE_EN
    phase_d = '0;
    if (nxt == ST_DONE && cur == ST_DONE)
      phase_d = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    beep_d = beep_d && (phase_d < PH_HALF);
`endif
  end

  assign state = cur;

endmodule

// File: doc/microwave_controller.md
Name: microwave_controller

Overview:
Top-level sequencing FSM for the microwave. It owns keypad time entry (enables and clears the timer-entry block) and starts, pauses, resumes and stops the countdown timer. It also drives the magnetron enable and the end-of-cook beeper. It sits between the front-panel buttons and door switch and the timer-entry/countdown datapath, all on the single 100 Hz system clock.

Parameters:
BEEP_CYCLES, 300, length of the done beep in clk cycles (3 s at 100 Hz); legal range 1..1023.
BEEP_HALF, 50, half-period in cycles of the pulsed beep pattern (used only with the optional feature).

Ports:
clk  in  1  100 Hz system clock; all logic on its rising edge.
clearn  in  1  reset, synchronous, active-low.
startn  in  1  start button, active-low level; the controller acts on its press edge.
stopn  in  1  stop/clear button, active-low level; the controller acts on its press edge.
door_closed  in  1  1 = door closed.
key_valid  in  1  one-cycle pulse when the entry block accepts a digit.
entry_zero  in  1  1 = entered time is 0:00.
time_zero  in  1  1 = countdown value has reached 0:00.
timer_enablen  out  1  to timer-entry enablen; 0 holds the entry cleared.
count_loadn  out  1  active-low one-cycle load of the entered time into the countdown.
count_en  out  1  countdown decrement enable.
mag_on  out  1  magnetron enable.
beep  out  1  beeper drive.
state  out  3  current state code, for display/debug.

Behaviour:
- Reset (clearn=0 at a clk edge):
  - state=IDLE.
  - timer_enablen=0, count_loadn=1, count_en=0, mag_on=0, beep=0.
  - Edge-detector history is set to 1, so a button already held through reset does not register as a press.
  - Beep counter is cleared.
  - Reset mid-cook returns to IDLE on the same edge.
- Press detection:
  - start_p=1 for exactly one cycle when startn is 0 now and was 1 last cycle; stop_p is the same on stopn.
  - A held button gives exactly one press.
- States and outputs:
  - IDLE=0: timer_enablen=0. Moves to SET on key_valid.
  - SET=1: timer_enablen=1.
  - LOAD=2: count_loadn=0 for exactly one cycle.
  - COOK=3: count_en=1, mag_on=1.
  - PAUSE=4: count_en=0, mag_on=0.
  - DONE=5: beep active while beep counter is less than BEEP_CYCLES.
  - All outputs are registered and change on the clk edge of the state transition.
- Transition priority, highest first, evaluated every cycle:
  1. stop_p
  2. door open
  3. time_zero
  4. start_p
- Transitions:
  - SET:
    - stop_p → IDLE.
    - start_p with door_closed=1 and entry_zero=0 → LOAD.
    - start_p with the door open or entry zero is ignored; stay in SET.
  - LOAD → COOK unconditionally after 1 cycle.
    - stop_p during LOAD → IDLE, so the countdown is loaded but never enabled.
  - COOK:
    - stop_p → PAUSE.
    - door_closed=0 → PAUSE; mag_on drops on that same edge.
    - time_zero=1 → DONE.
    - time_zero is ignored in the first COOK cycle after LOAD, while the countdown output settles.
  - PAUSE:
    - stop_p → IDLE, clearing the entry.
    - start_p with door_closed=1 and time_zero=0 → COOK, resuming with no reload.
    - start_p with the door open is ignored.
  - DONE:
    - stop_p → IDLE.
    - door_closed 1→0 → IDLE.
    - Otherwise stay in DONE after the beep expires.
- Beep counter:
  - 10 bits; cleared on entry to DONE; increments each DONE cycle; saturates at BEEP_CYCLES with no wrap.
  - beep=1 while counter < BEEP_CYCLES.
- Simultaneous events:
  - start_p and stop_p in the same cycle resolve as stop.
  - key_valid in any state other than IDLE does not change state.
- Undefined state codes 6 and 7 go to IDLE on the next edge.

Optional Feature:
MWC_BEEP_PULSE_EN
- Defined: during the beep window, beep alternates BEEP_HALF cycles on and BEEP_HALF cycles off, starting with on. This uses an extra phase counter cleared on entry to DONE.
- Undefined: beep is a continuous 1 for BEEP_CYCLES. BEEP_HALF is unused and no phase counter is built.

Decomposition:
- Package microwave_pkg holds:
  - The state codes (IDLE..DONE, 3 bits).
  - BEEP counter width (10).
  - The default BEEP_CYCLES value.
- One sub-module, press_detect_n: registered active-low press-edge detector with synchronous active-low reset, instantiated twice (start, stop).
- FSM and beep logic stay in microwave_controller.

Test Plan:
- Reset, then key_valid pulse → state=1, timer_enablen=1; start_p with door closed and entry_zero=0 → count_loadn=0 for one cycle, then state=3, mag_on=1, count_en=1.
- In COOK, door_closed=0 → same edge: state=4, mag_on=0, count_en=0; close the door and press start → state=3, count_loadn stays 1 (no reload).
- In COOK, raise time_zero → DONE, beep=1 for exactly 300 cycles then 0; with MWC_BEEP_PULSE_EN, beep is 1 for 50 cycles, 0 for 50, repeating until cycle 300.
- In SET, start pressed with entry_zero=1 or the door open → stays in SET, count_loadn stays 1; startn held low for 200 cycles gives exactly one LOAD.
- startn and stopn pressed on the same edge in SET → IDLE; stop in PAUSE → IDLE with timer_enablen=0.
- clearn=0 during COOK → next edge: state=0, all outputs at their reset values; startn held low across reset release → no press registered.
